// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one PFA slice stepped over WIDTH bits,
// with operand/result shift registers and an IDLE/RUN/DONE controller.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             zero_o
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic s_w, p_w, g_n_w, c_nx;

   PFA u_pfa (
      .a_i   (opa_q[0]),
      .b_i   (opb_q[0]),
      .c_i   (carry_q),
      .s_o   (s_w),
      .p_o   (p_w),
      .g_n_o (g_n_w)
   );

   assign c_nx = ~g_n_w | (p_w & carry_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               opa_d   = a_i;
               opb_d   = sub_i ? ~b_i : b_i;
               carry_d = sub_i;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            carry_d = c_nx;
            res_d   = {s_w, res_q[WIDTH-1:1]};
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               // carry_q here is the carry into the MSB slice
               sum_d   = res_d;
               cout_d  = c_nx;
               ovf_d   = carry_q ^ c_nx;
               zero_d  = (res_d == '0);
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = (state_q == RUN);
   assign done_o = (state_q == DONE);
   assign sum_o  = sum_q;
   assign cout_o = cout_q;
   assign ovf_o  = ovf_q;
   assign zero_o = zero_q;

endmodule

module PFA (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic p_o,
   output logic g_n_o
);

   assign p_o   = a_i ^ b_i;
   assign g_n_o = ~(a_i & b_i);
   assign s_o   = p_o ^ c_i;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: table vectors, random ops against an arithmetic
// model, and hand sequences for handshake, reset and result-hold behaviour.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy_o;
   logic         done_o;
   logic [W-1:0] sum_o;
   logic         cout_o;
   logic         ovf_o;
   logic         zero_o;

   typedef struct {
      logic         sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[10];
   int   errs   = 0;
   int   checks = 0;
   int   dones  = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .sub_i   (sub),
      .a_i     (a),
      .b_i     (b),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .sum_o   (sum_o),
      .cout_o  (cout_o),
      .ovf_o   (ovf_o),
      .zero_o  (zero_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   function automatic vec_t mk(input logic s, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W-1:0] r,
                               input logic c, input logic o, input logic z);
      vec_t v;
      v.sub = s; v.a = x; v.b = y;
      v.sum = r; v.cout = c; v.ovf = o; v.zero = z;
      return v;
   endfunction

   function automatic vec_t model(input logic s, input logic [W-1:0] x,
                                  input logic [W-1:0] y);
      vec_t         v;
      logic [W-1:0] yy;
      logic [W:0]   t;
      yy = s ? ~y : y;
      t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
      v.sub = s; v.a = x; v.b = y;
      v.sum  = t[W-1:0];
      v.cout = t[W];
      v.ovf  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
      v.zero = (t[W-1:0] == '0);
      return v;
   endfunction

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge clk) begin
      vec_t e;
      chk("busy_done_excl", {31'd0, busy_o & done_o}, 32'd0);
      if (done_o) begin
         dones++;
         chk("done_expected", {31'd0, exp_q.size() > 0}, 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sum", {24'd0, sum_o}, {24'd0, e.sum});
            chk("cout", {31'd0, cout_o}, {31'd0, e.cout});
            chk("ovf", {31'd0, ovf_o}, {31'd0, e.ovf});
            chk("zero", {31'd0, zero_o}, {31'd0, e.zero});
         end
      end
   end

   task automatic do_op(input vec_t v, input bit hold,
                        input logic [W-1:0] hv);
      bit bok;
      bit hok;
      bok = 1'b1;
      hok = 1'b1;
      @(negedge clk);
      exp_q.push_back(v);
      start = 1'b1; sub = v.sub; a = v.a; b = v.b;
      @(posedge clk);
      #1 start = 1'b0;
      a = W'($urandom); b = W'($urandom);
      for (int i = 1; i <= W; i++) begin
         @(negedge clk);
         if (busy_o !== 1'b1 || done_o !== 1'b0) bok = 1'b0;
         if (hold && sum_o !== hv) hok = 1'b0;
      end
      chk("busy_window", {31'd0, bok}, 32'd1);
      if (hold) chk("sum_hold", {31'd0, hok}, 32'd1);
      @(negedge clk);
      chk("done_latency", {31'd0, done_o}, 32'd1);
   endtask

   initial begin
      int   d0;
      vec_t vx;
      vec_t vy;

      tbl[0] = mk(0, 8'h3C, 8'h05, 8'h41, 0, 0, 0);
      tbl[1] = mk(0, 8'h7F, 8'h01, 8'h80, 0, 1, 0);
      tbl[2] = mk(0, 8'hFF, 8'h01, 8'h00, 1, 0, 1);
      tbl[3] = mk(1, 8'h05, 8'h05, 8'h00, 1, 0, 1);
      tbl[4] = mk(1, 8'h00, 8'h01, 8'hFF, 0, 0, 0);
      tbl[5] = mk(1, 8'h80, 8'h01, 8'h7F, 1, 1, 0);
      tbl[6] = mk(0, 8'h80, 8'h80, 8'h00, 1, 1, 1);
      tbl[7] = mk(1, 8'h7F, 8'hFF, 8'h80, 0, 1, 0);
      tbl[8] = mk(0, 8'h12, 8'h34, 8'h46, 0, 0, 0);
      tbl[9] = mk(1, 8'h50, 8'h20, 8'h30, 1, 0, 0);

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {18'd0, busy_o, done_o, sum_o, cout_o, ovf_o, zero_o},
          32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) do_op(tbl[i], 1'b0, '0);

      for (int i = 0; i < 6; i++)
         do_op(model(1'($urandom), W'($urandom), W'($urandom)), 1'b0, '0);

      // start pulsed again during RUN must be ignored
      @(negedge clk);
      exp_q.push_back(mk(0, 8'h10, 8'h20, 8'h30, 0, 0, 0));
      d0 = dones;
      start = 1'b1; sub = 1'b0; a = 8'h10; b = 8'h20;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; a = 8'hAA; b = 8'h55;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (W + 6) @(negedge clk);
      chk("single_done", dones - d0, 32'd1);

      // start held through DONE launches the next op after one IDLE cycle
      vx = tbl[9];
      vy = mk(0, 8'h01, 8'hFF, 8'h00, 1, 0, 1);
      @(negedge clk);
      exp_q.push_back(vx);
      exp_q.push_back(vy);
      start = 1'b1; sub = vx.sub; a = vx.a; b = vx.b;
      @(posedge clk);
      #1 sub = vy.sub; a = vy.a; b = vy.b;
      repeat (W + 1) @(negedge clk);
      chk("held_done", {31'd0, done_o}, 32'd1);
      @(negedge clk);
      chk("held_gap_idle", {30'd0, busy_o, done_o}, 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("held_busy_rise", {31'd0, busy_o}, 32'd1);
      repeat (W) @(negedge clk);
      chk("held_done2", {31'd0, done_o}, 32'd1);

      // reset at RUN cycle 4 aborts with no done
      do_op(tbl[0], 1'b0, '0);
      @(negedge clk);
      start = 1'b1; sub = 1'b0; a = 8'h3C; b = 8'h05;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      d0 = dones;
      @(negedge clk);
      chk("rst_mid_outs",
          {18'd0, busy_o, done_o, sum_o, cout_o, ovf_o, zero_o}, 32'd0);
      repeat (W + 4) @(negedge clk);
      chk("rst_no_done", dones - d0, 32'd0);
      do_op(mk(0, 8'h01, 8'h01, 8'h02, 0, 0, 0), 1'b0, '0);

      // reset beats a simultaneous start
      @(negedge clk);
      rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
      @(posedge clk);
      #1 rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst_beats_start", {31'd0, busy_o}, 32'd0);
      chk("rst_clears_sum", {24'd0, sum_o}, 32'd0);

      // previous result holds during the next RUN
      do_op(tbl[8], 1'b0, '0);
      do_op(mk(0, 8'hFF, 8'hFF, 8'hFE, 1, 0, 0), 1'b1, 8'h46);

      repeat (4) @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
